// File: rtl/vga_timing_gen.sv
// Two-mode VGA timing generator: per-mode pixel divider, sync polarity and
// frame-boundary mode switching, with an optional tick-clocked sync delay line.
module vga_timing_gen #(
  parameter logic [47:0] M0_H       = {12'd800, 12'd56, 12'd120, 12'd64},
  parameter logic [47:0] M0_V       = {12'd600, 12'd37, 12'd6,   12'd23},
  parameter int          M0_DIV     = 1,
  parameter logic [1:0]  M0_POL     = 2'b11,
  parameter logic [47:0] M1_H       = {12'd640, 12'd16, 12'd96,  12'd48},
  parameter logic [47:0] M1_V       = {12'd480, 12'd10, 12'd2,   12'd33},
  parameter int          M1_DIV     = 2,
  parameter logic [1:0]  M1_POL     = 2'b00,
  parameter int          COL_W      = 11,
  parameter int          ROW_W      = 10,
  parameter int          SYNC_DELAY = 0,
  parameter logic        MODE_RESET = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode_sel,
  output logic             mode_active,
  output logic             pix_en,
  output logic [COL_W-1:0] display_col,
  output logic [ROW_W-1:0] display_row,
  output logic             visible,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
);

  // Field slices of a packed {active, front porch, sync, back porch} word.
  function automatic logic [12:0] f_act(input logic [47:0] p);
    return 13'(p[47:36]);
  endfunction
  function automatic logic [12:0] f_ss(input logic [47:0] p);
    return 13'(p[47:36]) + 13'(p[35:24]);
  endfunction
  function automatic logic [12:0] f_se(input logic [47:0] p);
    return 13'(p[47:36]) + 13'(p[35:24]) + 13'(p[23:12]);
  endfunction
  function automatic logic [12:0] f_tot(input logic [47:0] p);
    return 13'(p[47:36]) + 13'(p[35:24]) + 13'(p[23:12]) + 13'(p[11:0]);
  endfunction

  localparam logic [1:0][12:0] H_ACT = {f_act(M1_H), f_act(M0_H)};
  localparam logic [1:0][12:0] H_SS  = {f_ss(M1_H),  f_ss(M0_H)};
  localparam logic [1:0][12:0] H_SE  = {f_se(M1_H),  f_se(M0_H)};
  localparam logic [1:0][12:0] H_TOT = {f_tot(M1_H), f_tot(M0_H)};
  localparam logic [1:0][12:0] V_ACT = {f_act(M1_V), f_act(M0_V)};
  localparam logic [1:0][12:0] V_SS  = {f_ss(M1_V),  f_ss(M0_V)};
  localparam logic [1:0][12:0] V_SE  = {f_se(M1_V),  f_se(M0_V)};
  localparam logic [1:0][12:0] V_TOT = {f_tot(M1_V), f_tot(M0_V)};
  localparam logic [1:0][1:0]  DIVM1 = {2'(M1_DIV - 1), 2'(M0_DIV - 1)};
  localparam logic [1:0][1:0]  POL   = {M1_POL, M0_POL};

  logic             mode_q, mode_d, sync1_q, sync2_q;
  logic [1:0]       div_q, div_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             tick, eol, eof;
  logic             vis_d, hs_raw, vs_raw, hs_del, vs_del;
  logic             pix_en_q, vis_q, hs_q, vs_q, ls_q, fs_q;

  always_comb begin
    tick   = (div_q == DIVM1[mode_q]);
    eol    = (13'(col_q) == H_TOT[mode_q] - 13'd1);
    eof    = eol && (13'(row_q) == V_TOT[mode_q] - 13'd1);
    mode_d = mode_q;
    col_d  = col_q;
    row_d  = row_q;
    div_d  = tick ? 2'd0 : 2'(div_q + 2'd1);
    if (tick) begin
      if (eof) begin
        mode_d = sync2_q;
        col_d  = '0;
        row_d  = '0;
      end else if (eol) begin
        col_d  = '0;
        row_d  = ROW_W'(row_q + 1'b1);
      end else begin
        col_d  = COL_W'(col_q + 1'b1);
      end
    end
    // Decode from the post-tick counters and mode so everything lines up.
    vis_d  = (13'(col_d) < H_ACT[mode_d]) && (13'(row_d) < V_ACT[mode_d]);
    hs_raw = ((13'(col_d) >= H_SS[mode_d]) && (13'(col_d) < H_SE[mode_d]))
             ? POL[mode_d][1] : ~POL[mode_d][1];
    vs_raw = ((13'(row_d) >= V_SS[mode_d]) && (13'(row_d) < V_SE[mode_d]))
             ? POL[mode_d][0] : ~POL[mode_d][0];
  end

  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign hs_del = hs_raw;
      assign vs_del = vs_raw;
    end else begin : g_dly
      logic [SYNC_DELAY-1:0] hd_q, vd_q;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          hd_q <= {SYNC_DELAY{~POL[MODE_RESET][1]}};
          vd_q <= {SYNC_DELAY{~POL[MODE_RESET][0]}};
        end else if (tick) begin
          hd_q[0] <= hs_raw;
          vd_q[0] <= vs_raw;
          for (int k = 1; k < SYNC_DELAY; k++) begin
            hd_q[k] <= hd_q[k-1];
            vd_q[k] <= vd_q[k-1];
          end
        end
      end
      assign hs_del = hd_q[SYNC_DELAY-1];
      assign vs_del = vd_q[SYNC_DELAY-1];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= MODE_RESET;
      sync2_q  <= MODE_RESET;
      mode_q   <= MODE_RESET;
      div_q    <= '0;
      col_q    <= COL_W'(H_TOT[MODE_RESET] - 13'd1);
      row_q    <= ROW_W'(V_TOT[MODE_RESET] - 13'd1);
      pix_en_q <= 1'b0;
      vis_q    <= 1'b0;
      hs_q     <= ~POL[MODE_RESET][1];
      vs_q     <= ~POL[MODE_RESET][0];
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      sync1_q  <= mode_sel;
      sync2_q  <= sync1_q;
      div_q    <= div_d;
      pix_en_q <= tick;
      ls_q     <= tick && (col_d == '0);
      fs_q     <= tick && (col_d == '0) && (row_d == '0);
      if (tick) begin
        mode_q <= mode_d;
        col_q  <= col_d;
        row_q  <= row_d;
        vis_q  <= vis_d;
        hs_q   <= hs_del;
        vs_q   <= vs_del;
      end
    end
  end

  assign mode_active = mode_q;
  assign pix_en      = pix_en_q;
  assign display_col = col_q;
  assign display_row = row_q;
  assign visible     = vis_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised two-mode VGA timing generator: next generation of the fixed 800x600@72 controller.
- Adds a per-mode pixel-clock divider, per-mode sync polarity, frame-boundary mode switching, line/frame strobes and a programmable sync delay to match the downstream pixel pipeline.
- Sits between the 50 MHz system clock and the pixel renderer / DAC outputs.

Parameters:
- M0_H, {12'd800,12'd56,12'd120,12'd64}: mode-0 horizontal {active, front porch, sync, back porch} in pixels, 4x12-bit packed.
- M0_V, {12'd600,12'd37,12'd6,12'd23}: mode-0 vertical fields in lines.
- M0_DIV, 1: mode-0 clocks per pixel (1..4).
- M0_POL, 2'b11: mode-0 {hsync, vsync} active level.
- M1_H, {12'd640,12'd16,12'd96,12'd48}: mode-1 horizontal fields.
- M1_V, {12'd480,12'd10,12'd2,12'd33}: mode-1 vertical fields.
- M1_DIV, 2: mode-1 clocks per pixel (25 MHz from 50 MHz).
- M1_POL, 2'b00: mode-1 {hsync, vsync} active level.
- COL_W, 11: column counter width.
- ROW_W, 10: row counter width.
- SYNC_DELAY, 0: hsync/vsync delay in pixel ticks (0..7).
- MODE_RESET, 0: mode entered at reset.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- mode_sel  in  1  requested mode; asynchronous source
- mode_active  out  1  mode currently generated
- pix_en  out  1  one-clock strobe: display outputs just advanced by one pixel
- display_col  out  COL_W  current column
- display_row  out  ROW_W  current row
- visible  out  1  col < H_ACT and row < V_ACT
- hsync  out  1  horizontal sync, level per POL
- vsync  out  1  vertical sync, level per POL
- line_start  out  1  one-clock pulse when col becomes 0
- frame_start  out  1  one-clock pulse when col and row both become 0

Behaviour:
- Per-mode totals:
  - HT = H_ACT + H_FP + H_SYNC + H_BP; VT likewise.
  - Mode 0: HT = 1040, VT = 666. Mode 1: HT = 800, VT = 525.
- hsync active for col in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC-1]:
  - Mode 0: cols 856..975. Mode 1: cols 656..751.
- vsync active for row in [V_ACT+V_FP, V_ACT+V_FP+V_SYNC-1]:
  - Mode 0: rows 637..642. Mode 1: rows 490..491.
- Divider:
  - div_cnt counts 0..DIV-1 of the active mode.
  - tick = (div_cnt == DIV-1). With DIV = 1, tick is high every clock.
- On tick, col advances; at HT-1 it wraps to 0 and row advances; at VT-1 row wraps to 0.
- All outputs are registered and updated together on the tick edge, decoded from the NEW counter values. Zero-cycle skew between col/row, visible and the undelayed syncs.
- pix_en is high for exactly the clock after each tick edge, i.e. while the new values are presented.
- line_start and frame_start are asserted only in a pix_en cycle.
- Reset (reset = 0, asynchronous):
  - mode_active = MODE_RESET; col = HT-1 and row = VT-1 of that mode; div_cnt = 0.
  - pix_en, visible, line_start, frame_start = 0.
  - hsync/vsync at inactive level; sync delay line filled with inactive levels.
  - Reset asserted mid-frame aborts the frame immediately.
  - First tick after release produces col = 0, row = 0, frame_start = 1, line_start = 1, visible = 1.
- Mode switch:
  - mode_sel passes through a 2-flop synchroniser (reset to MODE_RESET).
  - Synchronised value is loaded into mode_active only on the tick where col = HT-1 and row = VT-1.
  - New totals, polarity and divider apply from that tick on: next outputs are (0,0) of the new mode, and div_cnt restarts at 0.
  - A mid-frame request never truncates or extends the current frame. A request toggled and restored within one frame has no effect.
- Sync delay:
  - hsync/vsync pass through a SYNC_DELAY-deep shift register clocked by tick.
  - visible, col, row and strobes are not delayed.
  - SYNC_DELAY = 0 is a direct path.
- Polarity change at a mode switch applies to values entering the delay line; entries already in the line drain unchanged.
- Counter widths:
  - COL_W must cover max HT-1 and ROW_W must cover max VT-1.
  - Packed fields are unsigned 12-bit; sums use 13-bit arithmetic before compare.

Test Plan:
- Reset release, mode 0, DIV = 1 -> first clock after release: pix_en = 1, col = 0, row = 0, frame_start = 1, visible = 1. Frame period exactly 1040*666 = 692640 clocks.
- Mode 0 horizontal line -> hsync = 1 exactly for cols 856..975 (120 clocks); visible = 0 from col 800. line_start once per 1040 clocks.
- Mode 1 selected at reset (MODE_RESET = 1) -> pix_en every 2nd clock; hsync = 0 for cols 656..751, vsync = 0 for rows 490..491; frame = 800*525*2 = 840000 clocks.
- mode_sel 0->1 at row 300 of mode 0 -> mode 0 frame completes (row 665, col 1039), then frame_start with mode_active = 1 and pix_en halving.
- SYNC_DELAY = 2, mode 0 -> hsync asserts 2 ticks after col = 856 is presented (col = 858); visible edges unshifted.
- reset pulsed low at row 100, col 400 -> all outputs immediately at reset values; restart at (0,0) with frame_start after release.
